// File: rtl/rs_sfu_reader.sv
// Streams a byte range out of the result-SRAM SFU read port as OUT_W-bit beats,
// reading one LINE_W line at a time into a local buffer and zeroing bytes past the end.
module rs_sfu_reader #(
    parameter int LINE_W = 32768,
    parameter int OUT_W  = 256
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       total_bytes,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [31:0]       rd_addr,
    input  logic [LINE_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last
);

    localparam int              BEATS      = LINE_W / OUT_W;
    localparam int              BI_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]     BEAT_BYTES = 32'(OUT_W / 8);
    localparam logic [31:0]     LINE_BYTES = 32'(LINE_W / 8);
    localparam logic [BI_W-1:0] LAST_BEAT  = BI_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, STREAM, DONE} state_t;

    state_t            state;
    logic [31:0]       remaining;
    logic [BI_W-1:0]   beat;
    logic [LINE_W-1:0] line_buf;
    logic [OUT_W-1:0]  beat_slice;

    // Byte positions at or past the remaining count are forced to zero.
    function automatic logic [OUT_W-1:0] tail_mask(input logic [OUT_W-1:0] bytes_in,
                                                   input logic [31:0]      valid_bytes);
        logic [OUT_W-1:0] m;
        m = '0;
        for (int j = 0; j < OUT_W / 8; j++) begin
            if (32'(j) < valid_bytes) m[8*j +: 8] = bytes_in[8*j +: 8];
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (RSTn) begin
            state     <= IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            beat      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (total_bytes != 32'd0) begin
                            rd_addr   <= base_addr;
                            remaining <= total_bytes;
                            state     <= REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ:  state <= CAPT;
                CAPT: begin
                    beat  <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (out_ready) begin
                        if (remaining <= BEAT_BYTES) begin
                            remaining <= '0;
                            state     <= DONE;
                        end else begin
                            remaining <= remaining - BEAT_BYTES;
                            beat      <= beat + 1'b1;
                            // Line exhausted with bytes still owed: fetch the next line.
                            if (beat == LAST_BEAT) begin
                                rd_addr <= rd_addr + LINE_BYTES;
                                state   <= REQ;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffer is pure data; its contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (state == CAPT) line_buf <= rd_data;
    end

    assign beat_slice = line_buf[int'(beat) * OUT_W +: OUT_W];

    assign busy      = (state == REQ) || (state == CAPT) || (state == STREAM);
    assign done      = (state == DONE);
    assign rd_en     = (state == REQ);
    assign out_valid = (state == STREAM);
    assign out_last  = (state == STREAM) && (remaining <= BEAT_BYTES);
    assign out_data  = (state == STREAM) ? tail_mask(beat_slice, remaining) : '0;

endmodule

// File: tb/tb_rs_sfu_reader.sv
// Randomized bench for rs_sfu_reader: byte-addressed SRAM model, a queue-based stream
// model built from the job parameters, and a per-cycle compare process.
module tb_rs_sfu_reader;

    localparam int LINE_W = 32768;
    localparam int OUT_W  = 256;
    localparam int BB     = OUT_W / 8;
    localparam int LB     = LINE_W / 8;

    logic              clk = 1'b0;
    logic              RSTn;
    logic              start;
    logic [31:0]       base_addr;
    logic [31:0]       total_bytes;
    logic              busy, done, rd_en;
    logic [31:0]       rd_addr;
    logic [LINE_W-1:0] rd_data = '0;
    logic [LINE_W-1:0] line_tmp;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ready_mode = 0;

    logic [OUT_W-1:0] exp_data_q[$];
    bit               exp_last_q[$];
    logic [31:0]      exp_addr_q[$];
    logic [OUT_W-1:0] cap_q[$];
    logic [OUT_W-1:0] ref_q[$];

    rs_sfu_reader #(.LINE_W(LINE_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .RSTn(RSTn), .start(start), .base_addr(base_addr),
        .total_bytes(total_bytes), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    // SRAM: line valid the cycle after rd_en, scrambled otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int k = 0; k < LB; k++) line_tmp[8*k +: 8] = mem_byte(rd_addr + 32'(k));
            rd_data <= line_tmp;
        end else begin
            rd_data <= ~rd_data;
        end
    end

    task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_cycles(input int n);
        return 3 + (n + BB - 1) / BB + 2 * ((n + LB - 1) / LB - 1);
    endfunction

    task automatic plan_job(input logic [31:0] b, input int n);
        logic [OUT_W-1:0] w;
        int nb;
        int nl;
        nb = (n + BB - 1) / BB;
        nl = (n + LB - 1) / LB;
        for (int l = 0; l < nl; l++) exp_addr_q.push_back(b + 32'(l * LB));
        for (int t = 0; t < nb; t++) begin
            w = '0;
            for (int j = 0; j < BB; j++)
                if (t * BB + j < n) w[8*j +: 8] = mem_byte(b + 32'(t * BB + j));
            exp_data_q.push_back(w);
            exp_last_q.push_back(t == nb - 1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle comparison against the model queues.
    initial begin
        bit               prev_stall;
        logic [OUT_W-1:0] prev_data;
        logic             prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (RSTn !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (rd_en) begin
                    if (exp_addr_q.size() == 0) chk("unexpected_rd_en", OUT_W'(rd_en), '0);
                    else chk("rd_addr", OUT_W'(rd_addr), OUT_W'(exp_addr_q.pop_front()));
                end
                if (prev_stall) begin
                    chk("hold_valid", OUT_W'(out_valid), OUT_W'(1));
                    chk("hold_data", out_data, prev_data);
                    chk("hold_last", OUT_W'(out_last), OUT_W'(prev_last));
                end
                if (out_valid) begin
                    if (exp_data_q.size() == 0) begin
                        chk("unexpected_beat", OUT_W'(out_valid), '0);
                    end else begin
                        chk("out_data", out_data, exp_data_q[0]);
                        chk("out_last", OUT_W'(out_last), OUT_W'(exp_last_q[0]));
                        if (out_ready) begin
                            void'(exp_data_q.pop_front());
                            void'(exp_last_q.pop_front());
                            cap_q.push_back(out_data);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic run_job(input logic [31:0] b, input int n, input int mode, output int cyc);
        int d0;
        ready_mode = mode;
        plan_job(b, n);
        cap_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        base_addr   = b;
        total_bytes = 32'(n);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 30000) begin
            chk("busy_in_job", OUT_W'(busy), OUT_W'(1));
            start       = ($urandom_range(0, 7) == 0);
            base_addr   = $urandom;
            total_bytes = $urandom;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            chk("done_timeout", OUT_W'(done), OUT_W'(1));
        end else begin
            chk("busy_at_done", OUT_W'(busy), '0);
            start       = 1'b1;
            base_addr   = $urandom;
            total_bytes = 32'd64;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("start_ignored_in_done", OUT_W'(busy), '0);
        end
        @(negedge clk);
        chk("done_count", OUT_W'(done_cnt), OUT_W'(d0 + 1));
        chk("beats_left", OUT_W'(exp_data_q.size()), '0);
        chk("lines_left", OUT_W'(exp_addr_q.size()), '0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, OUT_W'(busy), '0);
        chk({tag, "_done"}, OUT_W'(done), '0);
        chk({tag, "_rd_en"}, OUT_W'(rd_en), '0);
        chk({tag, "_out_valid"}, OUT_W'(out_valid), '0);
        chk({tag, "_out_last"}, OUT_W'(out_last), '0);
        chk({tag, "_rd_addr"}, OUT_W'(rd_addr), '0);
        chk({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        int cyc;
        int n;
        int mode;
        int d0;
        int guard;
        RSTn        = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        total_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(posedge clk);
        #2;
        RSTn = 1'b0;

        // 64 bytes: rd_en in cycle 1, two beats, done in cycle 5.
        run_job(32'h100, 64, 0, cyc);
        chk("lat_64", OUT_W'(cyc), OUT_W'(5));
        chk("beats_64", OUT_W'(cap_q.size()), OUT_W'(2));
        if (cap_q.size() > 0) chk("byte0_64", OUT_W'(cap_q[0][7:0]), OUT_W'(8'h5B));

        // 40 bytes: second beat carries 8 bytes, rest zero.
        run_job(32'h100, 40, 0, cyc);
        chk("lat_40", OUT_W'(cyc), OUT_W'(exp_cycles(40)));
        chk("beats_40", OUT_W'(cap_q.size()), OUT_W'(2));
        if (cap_q.size() > 1) begin
            chk("b2_byte0_40", OUT_W'(cap_q[1][7:0]), OUT_W'(8'h7B));
            chk("b2_byte7_40", OUT_W'(cap_q[1][63:56]), OUT_W'(8'h7C));
            chk("b2_pad_40", OUT_W'(cap_q[1][255:64]), '0);
        end

        // 4100 bytes: full line, refill, one 4-byte beat.
        run_job(32'h2000, 4100, 0, cyc);
        chk("lat_4100", OUT_W'(cyc), OUT_W'(134));
        chk("beats_4100", OUT_W'(cap_q.size()), OUT_W'(129));
        if (cap_q.size() > 128) begin
            chk("tail_byte0_4100", OUT_W'(cap_q[128][7:0]), OUT_W'(8'h6A));
            chk("tail_pad_4100", OUT_W'(cap_q[128][255:32]), '0);
        end
        ref_q = cap_q;

        // Same job under alternating backpressure yields the same bytes.
        run_job(32'h2000, 4100, 1, cyc);
        chk("toggle_beats", OUT_W'(cap_q.size()), OUT_W'(ref_q.size()));
        for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++) chk("toggle_seq", cap_q[i], ref_q[i]);

        // Zero-length job.
        run_job(32'h500, 0, 0, cyc);
        chk("lat_zero", OUT_W'(cyc), OUT_W'(1));
        chk("beats_zero", OUT_W'(cap_q.size()), '0);

        // Reset in the middle of streaming a 256-byte job.
        ready_mode = 0;
        plan_job(32'h4000, 256);
        cap_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        base_addr   = 32'h4000;
        total_bytes = 32'd256;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (exp_data_q.size() > 5 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("abort_reached_stream", OUT_W'(exp_data_q.size() <= 5), OUT_W'(1));
        @(posedge clk);
        #2;
        RSTn = 1'b1;
        exp_data_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        check_idle_zero("abort");
        @(posedge clk);
        #2;
        RSTn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_no_done", OUT_W'(done_cnt), OUT_W'(d0));
        run_job(32'h4000, 256, 0, cyc);
        chk("lat_after_abort", OUT_W'(cyc), OUT_W'(exp_cycles(256)));

        // Address wrap across 2^32.
        run_job(32'hFFFF_F7F3, 5000, 2, cyc);

        // Random jobs.
        for (int r = 0; r < 10; r++) begin
            n    = (r % 3 == 0) ? int'($urandom_range(4000, 9000)) : int'($urandom_range(1, 200));
            mode = int'($urandom_range(0, 2));
            run_job($urandom, n, mode, cyc);
            if (mode == 0) chk("lat_random", OUT_W'(cyc), OUT_W'(exp_cycles(n)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_sfu_reader.md
RS_SFU_READER -- requirements
Module: rs_sfu_reader

Interface
REQ-001 The module SHALL have parameter LINE_W, default 32768, giving the result-SRAM SFU read line width in bits (LINE_BYTES = LINE_W/8 = 4096).
REQ-002 The module SHALL have parameter OUT_W, default 256, giving the SFU stream beat width in bits (BEAT_BYTES = OUT_W/8 = 32); LINE_W SHALL be an integer multiple of OUT_W.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered on it.
REQ-004 Port RSTn, input, 1 bit: synchronous, active-high reset; 1 sampled on a clk rising edge resets the block.
REQ-005 Port start, input, 1 bit: a 1-cycle job request; it is sampled only in IDLE.
REQ-006 Port base_addr, input, 32 bits: the result-SRAM byte address of the first byte; it is sampled with start.
REQ-007 Port total_bytes, input, 32 bits: the number of bytes to stream; it is sampled with start.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-009 Port done, output, 1 bit: a 1-cycle pulse at job completion.
REQ-010 Port rd_en, output, 1 bit: the SFU read strobe, which drives the SRAM SFU read-enable bit (RS_web[256]).
REQ-011 Port rd_addr, output, 32 bits: the SRAM read byte address.
REQ-012 Port rd_data, input, LINE_W bits: the SRAM SFU output line, valid the cycle after rd_en; byte k occupies bits [8k+7:8k].
REQ-013 Port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the stream handshake; a transfer occurs when both are 1 on a rising edge.
REQ-014 Port out_data, output, OUT_W bits: the beat payload; byte j of a beat occupies bits [8j+7:8j].
REQ-015 Port out_last, output, 1 bit: high on the final beat of a job.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, CAPT, STREAM and DONE, and only these states.
REQ-017 In IDLE with start=1 and total_bytes>0, the block SHALL latch base_addr into rd_addr, latch total_bytes into the remaining-byte counter, and go to REQ.
REQ-018 In IDLE with start=1 and total_bytes=0, the block SHALL go to DONE with no rd_en and no beats.
REQ-019 In REQ, rd_en SHALL be 1 for exactly one cycle with rd_addr stable; the next state is CAPT.
REQ-020 In CAPT, rd_en SHALL be 0, rd_data SHALL be captured into an internal line buffer at the cycle end, the beat index SHALL be set to 0, and the next state is STREAM.
REQ-021 In STREAM, out_valid SHALL be 1 and out_data SHALL equal line buffer bytes [beat*BEAT_BYTES +: BEAT_BYTES].
REQ-022 In STREAM, any byte position at or beyond the remaining byte count SHALL be driven as 0x00.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and all state SHALL hold unchanged.
REQ-024 On each transfer, the remaining count SHALL decrease by min(remaining, BEAT_BYTES) and the beat index SHALL increment.
REQ-025 out_last SHALL be 1 exactly when remaining <= BEAT_BYTES.
REQ-026 On a transfer with out_last=1, the next state SHALL be DONE.
REQ-027 On a transfer of beat LINE_W/OUT_W-1 with out_last=0, rd_addr SHALL advance by LINE_BYTES and the next state SHALL be REQ.
REQ-028 Address arithmetic SHALL be 32-bit and wrap modulo 2^32 with no error flag.
REQ-029 In DONE, done SHALL be 1 for one cycle and the next state is IDLE.
REQ-030 start SHALL be ignored outside IDLE, including in DONE.
REQ-031 Latency SHALL be: start sampled at edge 0 -> rd_en high in cycle 1 -> first out_valid in cycle 3.
REQ-032 Each line refill SHALL cost 2 cycles (REQ plus CAPT) with out_valid=0.
REQ-033 With out_ready held at 1, an N-byte job SHALL take 3 + ceil(N/BEAT_BYTES) + 2*(ceil(N/LINE_BYTES)-1) cycles from start to done.
REQ-034 The SRAM SHALL be read-only from this block; rd_en SHALL never be asserted outside REQ.

Reset
REQ-035 While RSTn=1, the block SHALL go to IDLE, and busy, done, rd_en, out_valid and out_last SHALL be 0.
REQ-036 While RSTn=1, rd_addr, out_data and the remaining-byte counter SHALL be 0.
REQ-037 A reset in any state mid-job SHALL abort the job with no done pulse; the line buffer contents are don't-care.
REQ-038 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-039 Scenario: base_addr=0x100, total_bytes=64, out_ready=1 -> rd_en in cycle 1 with rd_addr=0x100, 2 beats in cycles 3-4, out_last on beat 2, done in cycle 5.
REQ-040 Scenario: total_bytes=40 -> beat 2 carries bytes 32..39 and byte positions 8..31 are 0x00, with out_last=1.
REQ-041 Scenario: total_bytes=4100 -> 128 beats from line 0, rd_addr=base+4096 in a second REQ, then a single beat with 4 valid bytes, out_last=1 and done.
REQ-042 Scenario: out_ready toggled 0/1 every cycle -> each beat is held stable until accepted, and the byte sequence is identical to the out_ready=1 run.
REQ-043 Scenario: start with total_bytes=0 -> done the next cycle, and rd_en and out_valid never assert.
REQ-044 Scenario: RSTn=1 asserted during STREAM of a 256-byte job -> all outputs 0 the next cycle with no done pulse; a new start then runs cleanly.
